fx3_port_sched: RTL and testbench

- Round-robin scheduler that shares the single FX3 GPIF-II slave-FIFO bus between up to N port FSMs (data-port-in, data-port-out, control-in, control-out).
- Grants one requester at a time, drives the FX3 socket address, and waits out the address-to-flag setup time.
- Pulses the granted FSM's start input, waits for its done pulse, then enforces a bus turnaround gap before the next grant.
- A watchdog aborts a hung transaction.

---
 rtl/fx3_port_sched.sv | 197 +++++++++++++++++++
 tb/tb_fx3_port_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx3_port_sched.sv
// fx3_port_sched
// Round-robin scheduler that shares the single FX3 GPIF-II slave-FIFO bus
// between up to N_PORTS port FSMs. One requester is granted at a time. The
// scheduler drives that port's FX3 socket address and holds it for SETUP_CYC
// cycles so the FX3 flags become valid. It then pulses the port's start input
// and waits for its done pulse, with a watchdog bound of TMO_CYC cycles.
// Finally it leaves the bus idle for GAP_CYC cycles before the next grant.
//
// Ports:
//   clk_i       system clock
//   rstn_i      asynchronous active-low reset
//   en_i        scheduler enable (gates new grants only)
//   req_i       per-port service request (level)
//   strt_o      one-hot, single-cycle start pulse to the granted port FSM
//   done_i      per-port done pulse; only the granted port's bit is honoured
//   fx3_addr_o  FX3 socket address of the most recent grant
//   busy_o      high in every state except IDLE
//   gnt_o       one-hot current grant, held from SETUP through GAP
//   tmo_o       sticky watchdog flag
//   tmo_port_o  index of the port that timed out
//   tmo_clr_i   clears tmo_o (a simultaneous timeout wins)
module fx3_port_sched #(
  parameter int                          N_PORTS   = 4,
  parameter int                          ADDR_W    = 2,
  parameter logic [N_PORTS*ADDR_W-1:0]   PORT_ADDR = {2'd3, 2'd2, 2'd1, 2'd0},
  parameter int                          SETUP_CYC = 3,
  parameter int                          GAP_CYC   = 2,
  parameter int                          TMO_CYC   = 255
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                en_i,
  input  logic [N_PORTS-1:0]  req_i,
  output logic [N_PORTS-1:0]  strt_o,
  input  logic [N_PORTS-1:0]  done_i,
  output logic [ADDR_W-1:0]   fx3_addr_o,
  output logic                busy_o,
  output logic [N_PORTS-1:0]  gnt_o,
  output logic                tmo_o,
  output logic [2:0]          tmo_port_o,
  input  logic                tmo_clr_i
);

  localparam int PTR_W = $clog2(N_PORTS);
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_START,
    S_WAIT,
    S_GAP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [N_PORTS-1:0]   gnt_q, gnt_d;
  logic [N_PORTS-1:0]   strt_q, strt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 busy_q, busy_d;
  logic                 tmo_q, tmo_d;
  logic [2:0]           tmo_port_q, tmo_port_d;

  // Round-robin pick: first set request searching upward from ptr+1 with
  // wrap, so the most recently served port has the lowest priority.
  logic                 win_vld;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W-1:0]     cand;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    win_vld = 1'b0;
    win_idx = ptr_q;
    cand    = ptr_q;
    for (int k = 1; k <= N_PORTS; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % N_PORTS);
      if (!win_vld && req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Next-state and next-output logic. Every output comes from a register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    strt_d     = '0;
    tmo_d      = tmo_q;
    tmo_port_d = tmo_port_q;

    // A timeout below overrides this, so the set wins over the clear.
    if (tmo_clr_i) tmo_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // req_i is looked at only here; en_i low only blocks new grants.
        if (en_i && win_vld) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          addr_d         = PORT_ADDR[win_idx*ADDR_W +: ADDR_W];
          ptr_d          = win_idx;
          cnt_d          = CNT_W'(SETUP_CYC - 1);
          state_d        = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_q == '0) state_d = S_START;
        else             cnt_d   = cnt_q - 16'd1;
      end

      S_START: begin
        strt_d  = gnt_q;
        cnt_d   = CNT_W'(TMO_CYC - 1);
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // Done is checked before the watchdog, so a done on the final
        // watchdog cycle completes normally and leaves tmo_o alone.
        if (|(done_i & gnt_q) || cnt_q == '0) begin
          if (!(|(done_i & gnt_q))) begin
            tmo_d      = 1'b1;
            tmo_port_d = 3'(ptr_q);
          end
          // With no turnaround gap configured, the bus goes straight back to IDLE.
          if (GAP_CYC == 0) begin
            gnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d   = CNT_W'(GAP_CYC - 1);
            state_d = S_GAP;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_GAP: begin
        if (cnt_q == '0) begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // The pointer resets to the last port, so port 0 has first priority.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ptr_q      <= PTR_W'(N_PORTS - 1);
      gnt_q      <= '0;
      strt_q     <= '0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      tmo_q      <= 1'b0;
      tmo_port_q <= '0;
    end else begin
      // NOTE: non-blocking assignments, so all registers update together
      // from values sampled at the same edge.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      strt_q     <= strt_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      tmo_q      <= tmo_d;
      tmo_port_q <= tmo_port_d;
    end
  end

  assign strt_o     = strt_q;
  assign gnt_o      = gnt_q;
  assign fx3_addr_o = addr_q;
  assign busy_o     = busy_q;
  assign tmo_o      = tmo_q;
  assign tmo_port_o = tmo_port_q;

endmodule

// File: tb/tb_fx3_port_sched.sv
// tb_fx3_port_sched
// Directed bench for fx3_port_sched. Stimulus pushes the expected grant
// (port) of every start pulse, and of every watchdog event, into queues. A
// monitor on the falling clock edge pops and compares whenever the DUT
// presents a start pulse or raises tmo_o. Cycle-exact timing points are
// checked inline by the stimulus process.
module tb_fx3_port_sched;

  localparam int N     = 4;
  localparam int AW    = 2;
  localparam int SETUP = 3;
  localparam int GAP   = 2;
  localparam int TMO   = 16;

  logic          clk_i     = 1'b0;
  logic          rstn_i    = 1'b0;
  logic          en_i      = 1'b0;
  logic          tmo_clr_i = 1'b0;
  logic [N-1:0]  req_i     = '0;
  logic [N-1:0]  man_done  = '0;
  logic [N-1:0]  auto_done = '0;
  logic [N-1:0]  done_i;
  logic [N-1:0]  strt_o;
  logic [N-1:0]  gnt_o;
  logic [AW-1:0] fx3_addr_o;
  logic          busy_o;
  logic          tmo_o;
  logic [2:0]    tmo_port_o;

  assign done_i = man_done | auto_done;

  always #5 clk_i = ~clk_i;

  fx3_port_sched #(
    .N_PORTS   (N),
    .ADDR_W    (AW),
    .PORT_ADDR ({2'd3, 2'd2, 2'd1, 2'd0}),
    .SETUP_CYC (SETUP),
    .GAP_CYC   (GAP),
    .TMO_CYC   (TMO)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .en_i       (en_i),
    .req_i      (req_i),
    .strt_o     (strt_o),
    .done_i     (done_i),
    .fx3_addr_o (fx3_addr_o),
    .busy_o     (busy_o),
    .gnt_o      (gnt_o),
    .tmo_o      (tmo_o),
    .tmo_port_o (tmo_port_o),
    .tmo_clr_i  (tmo_clr_i)
  );

  int n_cmp    = 0;
  int n_err    = 0;
  int n_starts = 0;
  int exp_start_q[$];
  int exp_tmo_q[$];
  int addr_tbl[N] = '{0, 1, 2, 3};
  bit auto_en  = 1'b0;
  logic tmo_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_strt"},     strt_o,     0);
    check({tag, "_gnt"},      gnt_o,      0);
    check({tag, "_addr"},     fx3_addr_o, 0);
    check({tag, "_busy"},     busy_o,     0);
    check({tag, "_tmo"},      tmo_o,      0);
    check({tag, "_tmo_port"}, tmo_port_o, 0);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    tick(2);
    rstn_i = 1'b1;
  endtask

  task automatic wait_strt(input string tag, input int budget);
    int i;
    i = 0;
    while (strt_o == '0 && i < budget) begin
      tick(1);
      i++;
    end
    check({tag, "_strt_seen"}, (strt_o != '0), 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    i = 0;
    while (busy_o && i < budget) begin
      tick(1);
      i++;
    end
    check({tag, "_idle_seen"}, busy_o, 0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk_i) begin : mon
    int p;
    if (strt_o != '0) begin
      n_starts++;
      check("strt_onehot", $countones(strt_o), 1);
      if (exp_start_q.size() == 0) begin
        check("unexpected_start", strt_o, 0);
      end else begin
        p = exp_start_q.pop_front();
        check("start_port", strt_o, 32'(1) << p);
        check("start_gnt",  gnt_o,  32'(1) << p);
        check("start_addr", fx3_addr_o, addr_tbl[p]);
      end
    end
    if (tmo_o && !tmo_prev) begin
      if (exp_tmo_q.size() == 0) begin
        check("unexpected_tmo", tmo_o, 0);
      end else begin
        p = exp_tmo_q.pop_front();
        check("tmo_port", tmo_port_o, p);
      end
    end
    tmo_prev = tmo_o;
  end

  // Port FSM model: returns done two edges after its start pulse.
  always @(negedge clk_i) begin : resp
    logic [N-1:0] d;
    if (auto_en && strt_o != '0) begin
      d = strt_o;
      @(posedge clk_i);
      #1 auto_done = d;
      @(posedge clk_i);
      #1 auto_done = '0;
    end
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    int base;

    // Reset values.
    #3;
    check_reset_vals("reset");
    tick(2);
    rstn_i = 1'b1;
    en_i   = 1'b1;
    tick(1);

    // Single request on port 2.
    req_i = 4'b0100;
    exp_start_q.push_back(2);
    tick(1);
    check("t1_gnt",  gnt_o,      4'b0100);
    check("t1_addr", fx3_addr_o, 2);
    check("t1_busy", busy_o,     1);
    req_i = '0;
    tick(3);
    check("t1_strt_before", strt_o, 0);
    tick(1);
    check("t1_strt_pulse",  strt_o, 4'b0100);
    tick(1);
    check("t1_strt_after",  strt_o, 0);
    tick(3);
    man_done = 4'b0100;
    tick(1);
    man_done = '0;
    tick(1);
    check("t1_busy_gap",  busy_o, 1);
    tick(1);
    check("t1_busy_idle", busy_o, 0);
    check("t1_gnt_clr",   gnt_o,  0);
    check("t1_addr_hold", fx3_addr_o, 2);

    // All four requesting continuously: order 0,1,2,3,0,1.
    do_reset();
    auto_en = 1'b1;
    base = n_starts;
    exp_start_q.push_back(0);
    exp_start_q.push_back(1);
    exp_start_q.push_back(2);
    exp_start_q.push_back(3);
    exp_start_q.push_back(0);
    exp_start_q.push_back(1);
    req_i = 4'b1111;
    begin
      int i;
      i = 0;
      while (n_starts < base + 6 && i < 200) begin
        tick(1);
        i++;
      end
    end
    req_i = '0;
    check("t2_six_starts", n_starts, base + 6);
    wait_idle("t2", 50);
    tick(5);
    check("t2_no_extra_gnt", gnt_o, 0);
    check("t2_start_count", n_starts, base + 6);
    auto_en = 1'b0;

    // Stray done from a non-granted port is ignored.
    req_i = 4'b0010;
    exp_start_q.push_back(1);
    wait_strt("t3", 20);
    req_i = '0;
    tick(1);
    man_done = 4'b0001;
    tick(1);
    man_done = '0;
    tick(4);
    check("t3_busy_after_stray", busy_o, 1);
    check("t3_gnt_after_stray",  gnt_o,  4'b0010);
    man_done = 4'b0010;
    tick(1);
    man_done = '0;
    check("t3_busy_gap", busy_o, 1);
    tick(2);
    check("t3_busy_idle", busy_o, 0);

    // Watchdog on port 3.
    req_i = 4'b1000;
    exp_start_q.push_back(3);
    exp_tmo_q.push_back(3);
    wait_strt("t4", 20);
    req_i = '0;
    tick(TMO - 1);
    check("t4_tmo_early", tmo_o, 0);
    tick(1);
    check("t4_tmo_set",  tmo_o,      1);
    check("t4_tmo_port", tmo_port_o, 3);
    check("t4_busy_gap", busy_o,     1);
    tick(1);
    check("t4_busy_gap2", busy_o, 1);
    tick(1);
    check("t4_busy_idle", busy_o, 0);
    check("t4_gnt_clr",   gnt_o,  0);
    check("t4_tmo_sticky", tmo_o, 1);
    tmo_clr_i = 1'b1;
    tick(1);
    tmo_clr_i = 1'b0;
    check("t4_tmo_clr", tmo_o, 0);
    auto_en = 1'b1;
    req_i = 4'b0001;
    exp_start_q.push_back(0);
    wait_strt("t4_next", 20);
    req_i = '0;
    wait_idle("t4_next", 20);
    auto_en = 1'b0;

    // Done on the final watchdog cycle wins over the timeout.
    req_i = 4'b0100;
    exp_start_q.push_back(2);
    wait_strt("t4b", 20);
    req_i = '0;
    tick(TMO - 1);
    man_done = 4'b0100;
    tick(1);
    man_done = '0;
    check("t4b_no_tmo", tmo_o,  0);
    check("t4b_busy",   busy_o, 1);
    tick(2);
    check("t4b_idle",   busy_o, 0);

    // en_i dropped mid-transaction: it completes, then no new grant.
    do_reset();
    req_i = 4'b1111;
    exp_start_q.push_back(0);
    wait_strt("t5", 20);
    en_i = 1'b0;
    tick(2);
    base = n_starts;
    man_done = 4'b0001;
    tick(1);
    man_done = '0;
    wait_idle("t5", 10);
    tick(10);
    check("t5_no_gnt",  gnt_o,    0);
    check("t5_no_busy", busy_o,   0);
    check("t5_no_strt", n_starts, base);

    // Reset asserted during SETUP clears outputs without a clock edge.
    en_i = 1'b1;
    tick(1);
    check("t5_gnt_p1",  gnt_o,      4'b0010);
    check("t5_addr_p1", fx3_addr_o, 1);
    tick(1);
    #2 rstn_i = 1'b0;
    #1;
    check_reset_vals("async_rst");
    tick(1);
    rstn_i = 1'b1;
    auto_en = 1'b1;
    exp_start_q.push_back(0);
    tick(1);
    check("t5_first_gnt", gnt_o, 4'b0001);
    req_i = '0;
    wait_strt("t5_after_rst", 20);
    wait_idle("t5_after_rst", 20);
    auto_en = 1'b0;

    tick(3);
    check("start_queue_empty", exp_start_q.size(), 0);
    check("tmo_queue_empty",   exp_tmo_q.size(),   0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
